// File: rtl/imem_stream_loader.sv
// Program loader / verifier for the instruction memory.
// Streams words from the host link into memory (LOAD) or reads memory back
// and compares it against the stream (VERIFY). It keeps the core in reset
// until a command completes cleanly and reports checksum, word count and
// the byte address of the first failure.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; command checks happen on the start edge
// LOAD  | accepting stream words, one registered write per handshake
// VRD   | memory read issued for the current word
// VCMP  | waiting for the stream word and comparing it with read data
// FIN   | last write drains; done pulse and core release follow
module imem_stream_loader #(
    parameter int XLEN          = 32,
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int HOLD_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [XLEN-1:0]   base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [XLEN-1:0]   s_data,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [XLEN-1:0]   err_addr,
    output logic [XLEN-1:0]   checksum,
    output logic [ADDR_W:0]   words_done
);

    typedef enum logic [2:0] {IDLE, LOAD, VRD, VCMP, FIN} state_t;

    state_t            state;
    logic [ADDR_W:0]   count_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   rdata_q;
    logic              rd_fresh;

    logic [XLEN:0]     end_word;
    logic              range_bad;
    logic              last_word;
    logic [XLEN-1:0]   cmp_data;

    // End-of-transfer word index is computed one bit wider so a command
    // that runs past the top of memory cannot hide behind an overflow.
    always_comb begin
        end_word  = {3'b000, base_addr[XLEN-1:2]} + {{(XLEN-ADDR_W){1'b0}}, word_count};
        range_bad = (base_addr[1:0] != 2'b00) || (end_word > (XLEN+1)'(DEPTH));
        last_word = ((words_done + (ADDR_W+1)'(1)) == count_q);
        cmp_data  = rd_fresh ? mem_rdata : rdata_q;
    end

    // Command sequencer; every output is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            rd_fresh   <= 1'b0;
            s_ready    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            core_hold  <= 1'(HOLD_ON_RESET);
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
            checksum   <= '0;
            words_done <= '0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        checksum   <= '0;
                        words_done <= '0;
                        busy       <= 1'b1;
                        core_hold  <= 1'b1;
                        count_q    <= word_count;
                        addr_q     <= base_addr;
                        if (range_bad) begin
                            error    <= 1'b1;
                            err_addr <= base_addr;
                            busy     <= 1'b0;
                        end else if (word_count == '0) begin
                            state <= FIN;
                        end else if (!mode) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end else begin
                            state    <= VRD;
                            mem_re   <= 1'b1;
                            mem_addr <= base_addr;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        error    <= 1'b1;
                        err_addr <= addr_q;
                        busy     <= 1'b0;
                        s_ready  <= 1'b0;
                        state    <= IDLE;
                    end else if (s_valid) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= addr_q;
                        mem_wdata  <= s_data;
                        addr_q     <= addr_q + XLEN'(4);
                        checksum   <= checksum + s_data;
                        words_done <= words_done + (ADDR_W+1)'(1);
                        if (last_word) begin
                            s_ready <= 1'b0;
                            state   <= FIN;
                        end
                    end
                end
                VRD: begin
                    mem_re <= 1'b0;
                    if (abort) begin
                        error    <= 1'b1;
                        err_addr <= addr_q;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        rd_fresh <= 1'b1;
                        s_ready  <= 1'b1;
                        state    <= VCMP;
                    end
                end
                VCMP: begin
                    // Read data is only valid in the first VCMP cycle; keep a copy for stalls.
                    rdata_q  <= cmp_data;
                    rd_fresh <= 1'b0;
                    if (abort) begin
                        error    <= 1'b1;
                        err_addr <= addr_q;
                        busy     <= 1'b0;
                        s_ready  <= 1'b0;
                        state    <= IDLE;
                    end else if (s_valid) begin
                        s_ready <= 1'b0;
                        if (s_data != cmp_data) begin
                            error    <= 1'b1;
                            err_addr <= addr_q;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            addr_q     <= addr_q + XLEN'(4);
                            checksum   <= checksum + s_data;
                            words_done <= words_done + (ADDR_W+1)'(1);
                            if (last_word) begin
                                state <= FIN;
                            end else begin
                                state    <= VRD;
                                mem_re   <= 1'b1;
                                mem_addr <= addr_q + XLEN'(4);
                            end
                        end
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    core_hold <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
